mario_sprite_drawer: RTL and testbench

Pixel-pipeline stage between the VGA controller and the Mario sprite ROMs. Each cycle it takes the current draw coordinate and decides whether that pixel lies inside Mario's 21x21 bounding box. If it does, it computes the ROM read address, mirroring the column when Mario faces left. It also selects the animation frame and converts the returned ROM color into a pixel-on flag and color for the color mapper. Palette index 0 color (12'h808) is treated as transparent.

---
 rtl/mario_sprite_drawer_if.sv | 25 ++
 rtl/mario_sprite_drawer.sv | 105 ++++++++++
 tb/tb_mario_sprite_drawer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mario_sprite_drawer_if.sv
// rtl/mario_sprite_drawer_if.sv - pixel/ROM/frame signal bundle for the Mario sprite drawer
interface mario_sprite_drawer_if;
  logic        frame_start;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  mario_x;
  logic [9:0]  mario_y;
  logic        facing_left;
  logic        walking;
  logic [8:0]  read_address;
  logic [1:0]  frame_sel;
  logic [11:0] rom_color;
  logic        pixel_on;
  logic [11:0] pixel_color;

  modport master (
    output frame_start, DrawX, DrawY, mario_x, mario_y, facing_left, walking, rom_color,
    input  read_address, frame_sel, pixel_on, pixel_color
  );

  modport slave (
    input  frame_start, DrawX, DrawY, mario_x, mario_y, facing_left, walking, rom_color,
    output read_address, frame_sel, pixel_on, pixel_color
  );
endinterface

// File: rtl/mario_sprite_drawer.sv
// rtl/mario_sprite_drawer.sv - two-stage sprite hit test, ROM addressing and walk animation
// Frame state moves only on frame_start so a sprite never tears mid-frame.
module mario_sprite_drawer #(
  parameter int          SPRITE_W        = 21,
  parameter int          SPRITE_H        = 21,
  parameter int          FRAMES_PER_STEP = 6,
  parameter logic [11:0] TRANSPARENT     = 12'h808
) (
  input logic                  Clk,
  input logic                  Reset,
  mario_sprite_drawer_if.slave bus
);

  typedef enum logic [1:0] {
    ANIM_STAND = 2'd0,
    ANIM_WALK1 = 2'd1,
    ANIM_WALK2 = 2'd2,
    ANIM_WALK3 = 2'd3
  } anim_state_t;

  anim_state_t anim_state, anim_next;
  logic [2:0]  step_cnt, step_next;

  logic [9:0]  pos_x, pos_y;
  logic        facing;
  logic        inbox, inbox_d;
  logic [10:0] x_hi, y_hi;
  logic [8:0]  col_raw, col, row, addr;
  logic [8:0]  read_address_q;
  logic        pixel_on_q;
  logic [11:0] pixel_color_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      anim_state <= ANIM_STAND;
      step_cnt   <= 3'd0;
      pos_x      <= 10'd0;
      pos_y      <= 10'd0;
      facing     <= 1'b0;
    end else begin
      anim_state <= anim_next;
      step_cnt   <= step_next;
      if (bus.frame_start) begin
        pos_x  <= bus.mario_x;
        pos_y  <= bus.mario_y;
        facing <= bus.facing_left;
      end
    end
  end

  always_comb begin
    anim_next = anim_state;
    step_next = step_cnt;
    if (bus.frame_start) begin
      if (!bus.walking) begin
        anim_next = ANIM_STAND;
        step_next = 3'd0;
      end else if (anim_state == ANIM_STAND) begin
        anim_next = ANIM_WALK1;
        step_next = 3'd0;
      end else if (step_cnt == 3'(FRAMES_PER_STEP - 1)) begin
        step_next = 3'd0;
        case (anim_state)
          ANIM_WALK1: anim_next = ANIM_WALK2;
          ANIM_WALK2: anim_next = ANIM_WALK3;
          default:    anim_next = ANIM_WALK1;
        endcase
      end else begin
        step_next = step_cnt + 3'd1;
      end
    end
  end

  // Upper bounds carried at 11 bits so a box hugging column/row 1023 does not wrap.
  always_comb begin
    x_hi    = {1'b0, pos_x} + 11'(SPRITE_W);
    y_hi    = {1'b0, pos_y} + 11'(SPRITE_H);
    inbox   = (bus.DrawX >= pos_x) && ({1'b0, bus.DrawX} < x_hi) &&
              (bus.DrawY >= pos_y) && ({1'b0, bus.DrawY} < y_hi);
    col_raw = 9'(bus.DrawX - pos_x);
    col     = facing ? (9'(SPRITE_W - 1) - col_raw) : col_raw;
    row     = 9'(bus.DrawY - pos_y);
    addr    = (row << 4) + (row << 2) + row + col;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address_q <= 9'd0;
      inbox_d        <= 1'b0;
      pixel_on_q     <= 1'b0;
      pixel_color_q  <= 12'h000;
    end else begin
      read_address_q <= inbox ? addr : 9'd0;
      inbox_d        <= inbox;
      pixel_on_q     <= inbox_d && (bus.rom_color != TRANSPARENT);
      pixel_color_q  <= (inbox_d && (bus.rom_color != TRANSPARENT)) ? bus.rom_color : 12'h000;
    end
  end

  assign bus.read_address = read_address_q;
  assign bus.frame_sel    = anim_state;
  assign bus.pixel_on     = pixel_on_q;
  assign bus.pixel_color  = pixel_color_q;

endmodule

// File: tb/tb_mario_sprite_drawer.sv
// tb/tb_mario_sprite_drawer.sv - directed bench for mario_sprite_drawer
module tb_mario_sprite_drawer;
  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  mario_sprite_drawer_if bus ();

  mario_sprite_drawer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse(input logic [9:0] x, input logic [9:0] y,
                             input logic left, input logic walk);
    bus.mario_x     = x;
    bus.mario_y     = y;
    bus.facing_left = left;
    bus.walking     = walk;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    Reset           = 1'b1;
    bus.frame_start = 1'($urandom);
    bus.DrawX       = 10'($urandom);
    bus.DrawY       = 10'($urandom);
    bus.mario_x     = 10'($urandom);
    bus.mario_y     = 10'($urandom);
    bus.facing_left = 1'($urandom);
    bus.walking     = 1'($urandom);
    bus.rom_color   = 12'($urandom);
    tick();
    tick();
    checks++;
    if (bus.read_address !== 9'd0) begin
      errors++; $display("FAIL reset_read_address got %0d want 0", bus.read_address);
    end
    checks++;
    if (bus.frame_sel !== 2'd0) begin
      errors++; $display("FAIL reset_frame_sel got %0d want 0", bus.frame_sel);
    end
    checks++;
    if (bus.pixel_on !== 1'b0) begin
      errors++; $display("FAIL reset_pixel_on got %0b want 0", bus.pixel_on);
    end
    checks++;
    if (bus.pixel_color !== 12'h000) begin
      errors++; $display("FAIL reset_pixel_color got %h want 000", bus.pixel_color);
    end
    Reset           = 1'b0;
    bus.frame_start = 1'b0;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd600;
    bus.rom_color   = 12'h000;
    tick();
    frame_pulse(10'd0, 10'd0, 1'b0, 1'b0);
    checks++;
    if (bus.frame_sel !== 2'd0) begin
      errors++; $display("FAIL reset_first_frame_sel got %0d want 0", bus.frame_sel);
    end
  endtask

  task automatic test_address_right();
    logic [9:0] xs [3];
    logic [9:0] ys [3];
    logic [8:0] exp [3];
    xs = '{10'd100, 10'd120, 10'd105};
    ys = '{10'd50,  10'd70,  10'd52};
    exp = '{9'd0, 9'd440, 9'd47};
    frame_pulse(10'd100, 10'd50, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.DrawX = xs[i];
      bus.DrawY = ys[i];
      tick();
      checks++;
      if (bus.read_address !== exp[i]) begin
        errors++;
        $display("FAIL addr_right_%0d got %0d want %0d", i, bus.read_address, exp[i]);
      end
    end
  endtask

  task automatic test_mirror();
    frame_pulse(10'd100, 10'd50, 1'b1, 1'b0);
    bus.DrawX = 10'd100;
    bus.DrawY = 10'd51;
    tick();
    checks++;
    if (bus.read_address !== 9'd41) begin
      errors++; $display("FAIL mirror_left_edge got %0d want 41", bus.read_address);
    end
    bus.DrawX = 10'd120;
    tick();
    checks++;
    if (bus.read_address !== 9'd21) begin
      errors++; $display("FAIL mirror_right_edge got %0d want 21", bus.read_address);
    end
  endtask

  task automatic test_transparency();
    bus.DrawX     = 10'd105;
    bus.DrawY     = 10'd52;
    tick();
    bus.rom_color = 12'h808;
    tick();
    checks++;
    if (bus.pixel_on !== 1'b0 || bus.pixel_color !== 12'h000) begin
      errors++;
      $display("FAIL transparent got on=%0b color=%h want on=0 color=000", bus.pixel_on, bus.pixel_color);
    end
    bus.rom_color = 12'hF30;
    tick();
    checks++;
    if (bus.pixel_on !== 1'b1 || bus.pixel_color !== 12'hF30) begin
      errors++;
      $display("FAIL opaque got on=%0b color=%h want on=1 color=F30", bus.pixel_on, bus.pixel_color);
    end
  endtask

  task automatic test_edges();
    logic [9:0] xs [2];
    xs = '{10'd99, 10'd121};
    for (int i = 0; i < 2; i++) begin
      bus.DrawX     = xs[i];
      bus.DrawY     = 10'd60;
      bus.rom_color = 12'hF30;
      tick();
      checks++;
      if (bus.read_address !== 9'd0) begin
        errors++; $display("FAIL edge_addr_x%0d got %0d want 0", xs[i], bus.read_address);
      end
      tick();
      checks++;
      if (bus.pixel_on !== 1'b0) begin
        errors++; $display("FAIL edge_pixel_x%0d got %0b want 0", xs[i], bus.pixel_on);
      end
    end
    frame_pulse(10'd1020, 10'd50, 1'b0, 1'b0);
    bus.DrawX = 10'd3;
    bus.DrawY = 10'd55;
    tick();
    checks++;
    if (bus.read_address !== 9'd0) begin
      errors++; $display("FAIL nowrap_addr got %0d want 0", bus.read_address);
    end
    tick();
    checks++;
    if (bus.pixel_on !== 1'b0) begin
      errors++; $display("FAIL nowrap_pixel got %0b want 0", bus.pixel_on);
    end
    bus.DrawX = 10'd1023;
    tick();
    checks++;
    if (bus.read_address !== 9'd108) begin
      errors++; $display("FAIL high_edge_addr got %0d want 108", bus.read_address);
    end
    tick();
    checks++;
    if (bus.pixel_on !== 1'b1) begin
      errors++; $display("FAIL high_edge_pixel got %0b want 1", bus.pixel_on);
    end
  endtask

  task automatic test_animation();
    logic [1:0] exp;
    bus.DrawY = 10'd700;
    for (int p = 1; p <= 19; p++) begin
      frame_pulse(10'd100, 10'd50, 1'b0, 1'b1);
      exp = (p < 7) ? 2'd1 : (p < 13) ? 2'd2 : (p < 19) ? 2'd3 : 2'd1;
      checks++;
      if (bus.frame_sel !== exp) begin
        errors++; $display("FAIL anim_pulse_%0d got %0d want %0d", p, bus.frame_sel, exp);
      end
      bus.walking = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.frame_sel !== exp) begin
        errors++; $display("FAIL anim_hold_%0d got %0d want %0d", p, bus.frame_sel, exp);
      end
    end
    frame_pulse(10'd100, 10'd50, 1'b0, 1'b0);
    checks++;
    if (bus.frame_sel !== 2'd0) begin
      errors++; $display("FAIL anim_stop got %0d want 0", bus.frame_sel);
    end
  endtask

  task automatic test_reset_flush();
    frame_pulse(10'd100, 10'd50, 1'b0, 1'b1);
    bus.DrawX     = 10'd105;
    bus.DrawY     = 10'd52;
    bus.rom_color = 12'hF30;
    tick();
    tick();
    Reset           = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    checks++;
    if (bus.read_address !== 9'd0 || bus.pixel_on !== 1'b0 || bus.pixel_color !== 12'h000) begin
      errors++;
      $display("FAIL flush got addr=%0d on=%0b color=%h want 0 0 000",
               bus.read_address, bus.pixel_on, bus.pixel_color);
    end
    checks++;
    if (bus.frame_sel !== 2'd0) begin
      errors++; $display("FAIL reset_over_frame_start got %0d want 0", bus.frame_sel);
    end
    Reset           = 1'b0;
    bus.frame_start = 1'b0;
    tick();
    checks++;
    if (bus.read_address !== 9'd0) begin
      errors++; $display("FAIL post_reset_pos got %0d want 0", bus.read_address);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_address_right();
    test_mirror();
    test_transparency();
    test_edges();
    test_animation();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
